// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch sequencer.
package fetch_pkg;

    localparam int          INSTR_W           = 32;
    localparam logic [31:0] DEFAULT_RESET_PC  = 32'd40;
    localparam int          DEFAULT_MEM_WORDS = 250;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        HOLD,
        DRAIN,
        FAULT
    } fetch_state_t;

    // A fetch address is legal when it is below the byte size of the memory.
    function automatic logic pc_in_range(input logic [31:0] addr, input int mem_words);
        return addr < 32'(4 * mem_words);
    endfunction

endpackage

// File: rtl/instr_fetch_ctrl.sv
// Fetch sequencer: owns the PC, reads instruction words over req/ack and
// presents them to decode over valid/ready, with redirect and fault handling.
//
// state | meaning
// IDLE  | not fetching; waits for run, accepts redirects into pc
// REQ   | read request for pc outstanding
// HOLD  | instruction presented to decode, waiting for if_ready
// DRAIN | wrong-path read still outstanding; its data is discarded on ack
// FAULT | illegal pc seen; fetch halted until reset
module instr_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter int          MEM_WORDS = DEFAULT_MEM_WORDS
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               run,
    output logic               mem_req,
    output logic [31:0]        mem_addr,
    input  logic               mem_ack,
    input  logic [INSTR_W-1:0] mem_rdata,
    output logic               if_valid,
    input  logic               if_ready,
    output logic [INSTR_W-1:0] if_instr,
    output logic [31:0]        if_pc,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    output logic               fault,
    output logic [31:0]        fetch_count
);

    fetch_state_t       state, state_n;
    logic [31:0]        pc, pc_n;
    logic [31:0]        pending_pc, pending_n;
    logic [INSTR_W-1:0] instr_n;
    logic [31:0]        ifpc_n;
    logic               valid_n;
    logic               fault_n;
    logic [31:0]        count_n;
    logic [31:0]        target;
    logic               misaligned;

    assign misaligned = redirect_valid && (redirect_pc[1:0] != 2'b00);

    // pc is not touched while a wrong-path read drains, so it is also the
    // outstanding address in DRAIN.
    assign mem_addr = pc;
    assign mem_req  = (state == REQ) || (state == DRAIN);

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            pending_pc  <= 32'd0;
            if_instr    <= '0;
            if_pc       <= 32'd0;
            if_valid    <= 1'b0;
            fault       <= 1'b0;
            fetch_count <= 32'd0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            pending_pc  <= pending_n;
            if_instr    <= instr_n;
            if_pc       <= ifpc_n;
            if_valid    <= valid_n;
            fault       <= fault_n;
            fetch_count <= count_n;
        end
    end

    // Next-state and next-datapath decisions; every path into REQ is range checked.
    always_comb begin
        state_n   = state;
        pc_n      = pc;
        pending_n = pending_pc;
        instr_n   = if_instr;
        ifpc_n    = if_pc;
        valid_n   = if_valid;
        fault_n   = fault;
        count_n   = fetch_count;
        target    = pc;

        if ((state != FAULT) && misaligned) begin
            state_n = FAULT;
        end else begin
            case (state)
                IDLE: begin
                    if (redirect_valid) begin
                        target = redirect_pc;
                        pc_n   = redirect_pc;
                    end
                    if (run) begin
                        state_n = pc_in_range(target, MEM_WORDS) ? REQ : FAULT;
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        if (redirect_valid) begin
                            pc_n    = redirect_pc;
                            state_n = pc_in_range(redirect_pc, MEM_WORDS) ? REQ : FAULT;
                        end else begin
                            instr_n = mem_rdata;
                            ifpc_n  = pc;
                            pc_n    = pc + 32'd4;
                            valid_n = 1'b1;
                            state_n = HOLD;
                        end
                    end else if (redirect_valid) begin
                        pending_n = redirect_pc;
                        state_n   = DRAIN;
                    end
                end
                DRAIN: begin
                    target = redirect_valid ? redirect_pc : pending_pc;
                    if (redirect_valid) begin
                        pending_n = redirect_pc;
                    end
                    if (mem_ack) begin
                        pc_n    = target;
                        state_n = pc_in_range(target, MEM_WORDS) ? REQ : FAULT;
                    end
                end
                HOLD: begin
                    if (redirect_valid) begin
                        valid_n = 1'b0;
                        pc_n    = redirect_pc;
                        state_n = pc_in_range(redirect_pc, MEM_WORDS) ? REQ : FAULT;
                    end else if (if_ready) begin
                        count_n = fetch_count + 32'd1;
                        valid_n = 1'b0;
                        if (run) begin
                            state_n = pc_in_range(pc, MEM_WORDS) ? REQ : FAULT;
                        end else begin
                            state_n = IDLE;
                        end
                    end
                end
                FAULT: begin
                    state_n = FAULT;
                end
                default: begin
                    state_n = FAULT;
                end
            endcase
        end

        // Any entry into FAULT latches the flag and withdraws the instruction.
        if (state_n == FAULT) begin
            fault_n = 1'b1;
            valid_n = 1'b0;
        end
    end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed bench for instr_fetch_ctrl with an instruction memory model,
// configurable wait states and a per-cycle fetch-stream model.
module tb_instr_fetch_ctrl;

    logic        clk;
    logic        rst_n;
    logic        run;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fault;
    logic [31:0] fetch_count;

    int n_checks = 0;
    int n_fail   = 0;

    instr_fetch_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .run            (run),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_ack        (mem_ack),
        .mem_rdata      (mem_rdata),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fault          (fault),
        .fetch_count    (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory: 250 words, program at word 10, filler elsewhere.
    logic [31:0] mem [0:249];

    initial begin
        for (int i = 0; i < 250; i++) mem[i] = 32'hA500_0000 | 32'(i);
        mem[10] = 32'h2008_0002;
        mem[11] = 32'h2009_0002;
        mem[12] = 32'h200B_0002;
        mem[13] = 32'h0C00_0008;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a < 32'd1000) return mem[a[9:2]];
        return 32'd0;
    endfunction

    assign mem_rdata = mem_word(mem_addr);

    // Wait-state wrapper: ack after ws idle cycles of an asserted request.
    int        ws = 0;
    logic [3:0] wcnt;
    assign mem_ack = mem_req && (wcnt == ws[3:0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) wcnt <= 4'd0;
        else if (!mem_req || mem_ack) wcnt <= 4'd0;
        else wcnt <= wcnt + 4'd1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: bound expired at %0t", name, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_mem_req"},  mem_req, 0);
        chk({tag, "_mem_addr"}, mem_addr, 32'd40);
        chk({tag, "_if_valid"}, if_valid, 0);
        chk({tag, "_if_instr"}, if_instr, 0);
        chk({tag, "_if_pc"},    if_pc, 0);
        chk({tag, "_fault"},    fault, 0);
        chk({tag, "_count"},    fetch_count, 0);
    endtask

    // Fetch-stream model: the presented instruction is always the memory word
    // at the next expected pc; accepts advance it by 4, aligned redirects
    // replace it; the counter follows accepted handshakes.
    initial begin
        logic [31:0] m_pc;
        logic [31:0] m_cnt;
        logic        prev_req, prev_ack;
        logic [31:0] prev_addr;
        m_pc = 32'd40; m_cnt = 0; prev_req = 0; prev_ack = 0; prev_addr = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_pc = 32'd40; m_cnt = 0; prev_req = 0; prev_ack = 0;
            end else begin
                chk("mon_count", fetch_count, m_cnt);
                if (fault) begin
                    chk("mon_fault_req", mem_req, 0);
                    chk("mon_fault_valid", if_valid, 0);
                end else begin
                    if (if_valid) begin
                        chk("mon_if_pc", if_pc, m_pc);
                        chk("mon_if_instr", if_instr, mem_word(m_pc));
                    end
                    if (prev_req && !prev_ack && mem_req)
                        chk("mon_addr_hold", mem_addr, prev_addr);
                    if (redirect_valid && redirect_pc[1:0] == 2'b00) begin
                        m_pc = redirect_pc;
                    end else if (if_valid && if_ready) begin
                        m_cnt = m_cnt + 1;
                        m_pc  = m_pc + 4;
                    end
                end
                prev_req  = mem_req;
                prev_ack  = mem_ack;
                prev_addr = mem_addr;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] prog [4];
        logic        seen;
        prog[0] = 32'h2008_0002; prog[1] = 32'h2009_0002;
        prog[2] = 32'h200B_0002; prog[3] = 32'h0C00_0008;

        rst_n = 1'b1; run = 1'b0; if_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = 32'd0;
        #1 rst_n = 1'b0;
        #2 check_reset_values("reset");
        step();
        rst_n = 1'b1; run = 1'b1; if_ready = 1'b1;

        // Streaming with a zero-wait memory: one instruction per two cycles.
        step();
        for (int i = 0; i < 4; i++) begin
            chk("stream_req", mem_req, 1);
            chk("stream_addr", mem_addr, 32'd40 + 32'(4 * i));
            step();
            chk("stream_valid", if_valid, 1);
            chk("stream_instr", if_instr, prog[i]);
            chk("stream_pc", if_pc, 32'd40 + 32'(4 * i));
            step();
        end
        chk("stream_count", fetch_count, 32'd4);

        // Decode stall: the presented instruction holds, no new request.
        if_ready = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", if_valid, 1);
            chk("stall_instr", if_instr, 32'hA500_000E);
            chk("stall_pc", if_pc, 32'd56);
            chk("stall_req", mem_req, 0);
            chk("stall_count", fetch_count, 32'd4);
            step();
        end
        if_ready = 1'b1;
        step();
        chk("stall_release_count", fetch_count, 32'd5);

        // Redirect wins over a same-cycle accept in HOLD.
        step();
        chk("hold_pc_60", if_pc, 32'd60);
        redirect_valid = 1'b1; redirect_pc = 32'd64;
        step();
        redirect_valid = 1'b0;
        chk("redir_hold_valid", if_valid, 0);
        chk("redir_hold_count", fetch_count, 32'd5);
        chk("redir_hold_addr", mem_addr, 32'd64);
        step();
        chk("redir_hold_pc", if_pc, 32'd64);
        chk("redir_hold_instr", if_instr, 32'hA500_0010);

        // Three wait states: redirect during the wait drains the old read.
        ws = 3;
        step();
        chk("ws_req_addr", mem_addr, 32'd68);
        redirect_valid = 1'b1; redirect_pc = 32'd80;
        step();
        redirect_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("drain_req", mem_req, 1);
            chk("drain_addr", mem_addr, 32'd68);
            step();
        end
        chk("drain_next_addr", mem_addr, 32'd80);
        chk("drain_discard", if_valid, 0);

        // Newest redirect in DRAIN wins.
        redirect_valid = 1'b1; redirect_pc = 32'd92;
        step();
        redirect_pc = 32'd84;
        step();
        redirect_valid = 1'b0;
        chk("drain2_addr_a", mem_addr, 32'd80);
        step();
        chk("drain2_addr_b", mem_addr, 32'd80);
        step();
        chk("drain2_next_addr", mem_addr, 32'd84);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step();
            seen = if_valid;
        end
        if (!seen) timeout_fail("drain2_valid_wait");
        chk("drain2_if_pc", if_pc, 32'd84);
        chk("drain2_if_instr", if_instr, 32'hA500_0015);

        // Out-of-range redirect halts fetch.
        ws = 0;
        redirect_valid = 1'b1; redirect_pc = 32'd1000;
        step();
        redirect_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("range_fault", fault, 1);
            chk("range_fault_req", mem_req, 0);
            chk("range_fault_valid", if_valid, 0);
            chk("range_fault_count", fetch_count, 32'd6);
            step();
        end

        rst_n = 1'b0;
        #1 chk("fault_cleared", fault, 0);
        step();
        rst_n = 1'b1;
        step();
        chk("restart_addr", mem_addr, 32'd40);
        redirect_valid = 1'b1; redirect_pc = 32'd42;
        step();
        redirect_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("align_fault", fault, 1);
            chk("align_fault_req", mem_req, 0);
            step();
        end

        // Asynchronous reset in DRAIN.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1; ws = 3;
        step();
        redirect_valid = 1'b1; redirect_pc = 32'd100;
        step();
        redirect_valid = 1'b0;
        chk("pre_reset_drain_req", mem_req, 1);
        chk("pre_reset_drain_addr", mem_addr, 32'd40);
        #2 rst_n = 1'b0;
        #1 check_reset_values("async");
        step();
        rst_n = 1'b1; ws = 0;
        step();
        chk("post_reset_req", mem_req, 1);
        chk("post_reset_addr", mem_addr, 32'd40);
        step();
        chk("post_reset_pc", if_pc, 32'd40);
        chk("post_reset_instr", if_instr, 32'h2008_0002);

        // run low takes effect at the handshake: back to IDLE.
        run = 1'b0;
        step();
        step();
        chk("idle_req", mem_req, 0);
        chk("idle_count", fetch_count, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
